// File: rtl/vm_pkg.sv
// Shared definitions for the change dispense sequencer.
//   state_e : sequencer FSM states (explicit 3-bit encoding)
//   ONE_VAL / TWO_VAL : rupee value of each coin type
//   coin_e  : which hopper the current coin comes from
package vm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam int unsigned ONE_VAL = 1;
  localparam int unsigned TWO_VAL = 2;

  typedef enum logic {
    COIN_ONE = 1'b0,
    COIN_TWO = 1'b1
  } coin_e;

endpackage

// File: rtl/hopper_counter.sv
// Saturating up/down inventory counter for one coin hopper.
//   clk, reset : clock and synchronous active-high reset (loads INIT)
//   inc        : add one coin (saturates at all-ones)
//   dec        : remove one coin (holds at zero)
//   level      : current inventory
// inc and dec together cancel, leaving the level unchanged.
module hopper_counter #(
  parameter int          CNT_W = 6,
  parameter int unsigned INIT  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] level
);

  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);
  localparam logic [CNT_W-1:0] MAX_V  = '1;

  logic [CNT_W-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (inc && !dec) begin
      if (level_q != MAX_V) level_d = level_q + 1'b1;
    end else if (dec && !inc) begin
      if (level_q != '0) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) level_q <= INIT_V;
    else       level_q <= level_d;
  end

  assign level = level_q;

endmodule

// File: rtl/change_dispense_sequencer.sv
// Pays out change as greedy 2-rupee then 1-rupee coins, one coin at a time.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_amt     : change request; taken when req_valid & req_ready
//   req_ready             : high only in IDLE
//   eject_one/eject_two   : one-cycle coin drop command
//   eject_ack             : hopper confirms the drop (honoured in WAIT_ACK only)
//   refill_one/refill_two : add one coin to a hopper
//   fault_clr             : leave FAULT back to IDLE
//   busy/done/fault       : status; short_amt holds the unpaid remainder in FAULT
//   one_level/two_level   : hopper inventories
//   dbg_state             : current FSM state
// Handshakes: a request transfers on a clock edge where req_valid and
// req_ready are both high; req_amt must be stable while req_valid is high.
// Each eject pulse is answered by one eject_ack cycle within ACK_TIMEOUT
// cycles after the pulse, otherwise the sequencer faults.
module change_dispense_sequencer
  import vm_pkg::*;
#(
  parameter int          AMT_W       = 4,
  parameter int          CNT_W       = 6,
  parameter int unsigned ONE_INIT    = 20,
  parameter int unsigned TWO_INIT    = 20,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             eject_one,
  output logic             eject_two,
  input  logic             eject_ack,
  input  logic             refill_one,
  input  logic             refill_two,
  input  logic             fault_clr,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] short_amt,
  output logic [CNT_W-1:0] one_level,
  output logic [CNT_W-1:0] two_level,
  output logic [2:0]       dbg_state
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  coin_e            coin_q, coin_d;
  logic             dec_one, dec_two;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    short_d = short_q;
    timer_d = timer_q;
    coin_d  = coin_q;
    dec_one = 1'b0;
    dec_two = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amt;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Greedy pick; the level guards also keep the counters from underflowing.
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (rem_q >= AMT_W'(TWO_VAL) && two_level != '0) begin
          coin_d  = COIN_TWO;
          state_d = ST_EJECT;
        end else if (one_level != '0) begin
          coin_d  = COIN_ONE;
          state_d = ST_EJECT;
        end else begin
          short_d = rem_q;
          state_d = ST_FAULT;
        end
      end
      ST_EJECT: begin
        timer_d = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (eject_ack) begin
          if (coin_q == COIN_TWO) begin
            dec_two = 1'b1;
            rem_d   = rem_q - AMT_W'(TWO_VAL);
          end else begin
            dec_one = 1'b1;
            rem_d   = rem_q - AMT_W'(ONE_VAL);
          end
          state_d = ST_SELECT;
        end else if (timer_q == TMR_LAST) begin
          short_d = rem_q;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr) begin
          rem_d   = '0;
          short_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      short_q <= '0;
      timer_q <= '0;
      coin_q  <= COIN_ONE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      short_q <= short_d;
      timer_q <= timer_d;
      coin_q  <= coin_d;
    end
  end

  hopper_counter #(.CNT_W(CNT_W), .INIT(ONE_INIT)) u_one_hopper (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_one),
    .dec   (dec_one),
    .level (one_level)
  );

  hopper_counter #(.CNT_W(CNT_W), .INIT(TWO_INIT)) u_two_hopper (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_two),
    .dec   (dec_two),
    .level (two_level)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign eject_one = (state_q == ST_EJECT) && (coin_q == COIN_ONE);
  assign eject_two = (state_q == ST_EJECT) && (coin_q == COIN_TWO);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign done      = (state_q == ST_DONE);
  assign fault     = (state_q == ST_FAULT);
  assign short_amt = short_q;
  assign dbg_state = state_q;

endmodule
